// File: rtl/verin_adc_capture.sv
// MCP3201 SPI capture for the actuator position pot: periodic 12-bit conversions, 8-bit code to the PIO.
// Optional build macro VERIN_ADC_AVG4_EN: angle_raw becomes the mean of the last 4 accepted codes.
module verin_adc_capture #(
   parameter int CLK_DIV       = 25,
   parameter int SAMPLE_PERIOD = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        adc_miso,
   output logic        adc_sclk,
   output logic        adc_cs_n,
   output logic [11:0] angle_raw,
   output logic [7:0]  angle_out,
   output logic        data_valid,
   output logic        frame_err,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   localparam int PW = $clog2(SAMPLE_PERIOD);
   localparam int DW = $clog2(CLK_DIV);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   period_cnt;
   logic [DW-1:0]   div_cnt, div_nx;
   logic [3:0]      bit_cnt, bit_nx;
   logic            half, half_nx;
   logic            sample_en;
   logic [12:0]     sreg;
   logic [11:0]     raw_nx;
   logic            tick, div_last, frame_nx, accept, reject;

   // data_valid / frame_err are single-cycle strobes with no back-pressure;
   // angle_raw holds its value until the next accepted frame.
   assign tick      = (period_cnt == PW'(SAMPLE_PERIOD - 1));
   assign div_last  = (div_cnt == DW'(CLK_DIV - 1));
   assign frame_nx  = (state_nx == SETUP) || (state_nx == SHIFT) || (state_nx == HOLD);
   assign accept    = (state == DONE) && !sreg[12];
   assign reject    = (state == DONE) &&  sreg[12];
   assign angle_out = angle_raw[11:4];
   assign dbg_state = state;

   always_comb begin
      state_nx  = state;
      div_nx    = div_cnt;
      half_nx   = half;
      bit_nx    = bit_cnt;
      sample_en = 1'b0;
      case (state)
         IDLE: if (tick && enable) begin
            state_nx = SETUP;
            div_nx   = '0;
         end
         SETUP: if (div_last) begin
            state_nx = SHIFT;
            div_nx   = '0;
            half_nx  = 1'b0;
            bit_nx   = '0;
         end else div_nx = div_cnt + 1'b1;
         SHIFT: if (div_last) begin
            div_nx  = '0;
            half_nx = ~half;
            // rising SCLK edge: take Dout; falling edge after the 15th bit ends the shift
            if (!half) sample_en = 1'b1;
            else if (bit_cnt == 4'd14) state_nx = HOLD;
            else bit_nx = bit_cnt + 4'd1;
         end else div_nx = div_cnt + 1'b1;
         HOLD: if (div_last) begin
            state_nx = DONE;
            div_nx   = '0;
         end else div_nx = div_cnt + 1'b1;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

`ifdef VERIN_ADC_AVG4_EN
   logic [11:0] hist0, hist1, hist2;
   logic        primed;
   logic [13:0] sum4;

   assign sum4   = {2'b00, sreg[11:0]} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};
   assign raw_nx = primed ? sum4[13:2] : sreg[11:0];

   // first accepted code after reset fills the whole history
   always_ff @(posedge clk) begin
      if (reset) begin
         hist0  <= '0;
         hist1  <= '0;
         hist2  <= '0;
         primed <= 1'b0;
      end else if (accept) begin
         primed <= 1'b1;
         hist0  <= sreg[11:0];
         hist1  <= primed ? hist0 : sreg[11:0];
         hist2  <= primed ? hist1 : sreg[11:0];
      end
   end
`else
   assign raw_nx = sreg[11:0];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         period_cnt <= '0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         half       <= 1'b0;
         sreg       <= '0;
         adc_cs_n   <= 1'b1;
         adc_sclk   <= 1'b0;
         busy       <= 1'b0;
         angle_raw  <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         period_cnt <= tick ? '0 : period_cnt + 1'b1;
         state      <= state_nx;
         div_cnt    <= div_nx;
         bit_cnt    <= bit_nx;
         half       <= half_nx;
         if (sample_en) sreg <= {sreg[11:0], adc_miso};
         adc_cs_n   <= !frame_nx;
         adc_sclk   <= (state_nx == SHIFT) && half_nx;
         busy       <= frame_nx;
         data_valid <= accept;
         frame_err  <= reject;
         if (accept) angle_raw <= raw_nx;
      end
   end

endmodule

// File: tb/tb_verin_adc_capture.sv
// Bench for verin_adc_capture with a behavioural MCP3201 Dout model.
// Build with +define+VERIN_ADC_AVG4_EN to check the averaging variant.
module tb_verin_adc_capture;

   localparam int CLK_DIV = 2;
   localparam int SP      = 200;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        adc_miso = 1'b0;
   logic        adc_sclk, adc_cs_n, data_valid, frame_err, busy;
   logic [11:0] angle_raw;
   logic [7:0]  angle_out;
   logic [2:0]  dbg_state;

   verin_adc_capture #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP)) dut (
      .clk(clk), .reset(reset), .enable(enable), .adc_miso(adc_miso),
      .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .angle_raw(angle_raw),
      .angle_out(angle_out), .data_valid(data_valid), .frame_err(frame_err),
      .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [11:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // MCP3201 model: two sample-phase bits, null bit, B11..B0; Dout moves on SCLK falling edges
   logic [11:0] m_code = '0;
   logic        m_null = 1'b0;
   logic [14:0] m_frame;
   int          m_idx;
   assign m_frame = {2'b11, m_null, m_code};

   always @(negedge adc_cs_n) begin
      m_idx    = 0;
      adc_miso = m_frame[14];
   end
   always @(negedge adc_sclk) begin
      if (!adc_cs_n) begin
         m_idx++;
         if (m_idx < 15) adc_miso = m_frame[14 - m_idx];
      end
   end

   // bus monitor + scoreboard
   int   cs_falls = 0, cs_low = 0, rises = 0, bad_hi = 0, bad_lo = 0, run = 0;
   logic seen_fall = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b0;

   always @(negedge clk) begin
      logic [11:0] e;
      if (adc_cs_n === 1'b0 && prev_cs === 1'b1) begin
         cs_falls++;
         cs_low = 0; rises = 0; bad_hi = 0; bad_lo = 0; seen_fall = 1'b0; run = 0;
      end
      if (adc_cs_n === 1'b0) cs_low++;
      if (adc_sclk === 1'b1 && prev_sclk === 1'b0) begin
         rises++;
         if (seen_fall && run != CLK_DIV) bad_lo++;
         run = 1;
      end else if (adc_sclk === 1'b0 && prev_sclk === 1'b1) begin
         if (run != CLK_DIV) bad_hi++;
         seen_fall = 1'b1;
         run = 1;
      end else run++;
      if (data_valid === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_data_valid", {31'd0, data_valid}, 32'd0);
         else begin
            e = exp_q.pop_front();
            check("scoreboard_angle_raw", {20'd0, angle_raw}, {20'd0, e});
         end
      end
      prev_cs   = adc_cs_n;
      prev_sclk = adc_sclk;
   end

   // driver tasks
   task automatic wait_cs(input logic lvl, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3 * SP; i++) begin
         @(negedge clk); #1;
         if (adc_cs_n === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_frame(input logic [11:0] code, input logic nb, input logic ev,
                           input logic [11:0] raw, input logic [7:0] out, input bit drop_en);
      bit ok;
      m_code = code;
      m_null = nb;
      if (ev) exp_q.push_back(raw);
      wait_cs(1'b0, ok);
      check("cs_fall_in_time", {31'd0, ok}, 32'd1);
      if (!ok) return;
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      if (drop_en) enable = 1'b0;
      wait_cs(1'b1, ok);
      check("cs_rise_in_time", {31'd0, ok}, 32'd1);
      if (!ok) return;
      check("cs_low_cycles", cs_low, 32 * CLK_DIV);
      check("sclk_rises", rises, 15);
      check("sclk_high_width", bad_hi, 0);
      check("sclk_low_width", bad_lo, 0);
      check("no_dv_at_cs_rise", {31'd0, data_valid}, 32'd0);
      @(negedge clk); #1;
      check("data_valid_pulse", {31'd0, data_valid}, {31'd0, ev});
      check("frame_err_pulse", {31'd0, frame_err}, {31'd0, !ev});
      check("angle_raw", {20'd0, angle_raw}, {20'd0, raw});
      check("angle_out", {24'd0, angle_out}, {24'd0, out});
      @(negedge clk); #1;
      check("data_valid_drop", {31'd0, data_valid}, 32'd0);
      check("frame_err_drop", {31'd0, frame_err}, 32'd0);
      check("busy_after_frame", {31'd0, busy}, 32'd0);
   endtask

   typedef struct {
      logic [11:0] code;
      logic        nb;
      logic        ev;
      logic [11:0] raw;
      logic [7:0]  out;
   } vec_t;

   vec_t vecs[$];

   initial begin
      bit ok;
      int snap;
      logic [11:0] drop_raw;

`ifdef VERIN_ADC_AVG4_EN
      vecs.push_back('{12'h100, 1'b0, 1'b1, 12'h100, 8'h10});
      vecs.push_back('{12'h200, 1'b0, 1'b1, 12'h140, 8'h14});
      vecs.push_back('{12'h777, 1'b1, 1'b0, 12'h140, 8'h14});
      vecs.push_back('{12'h300, 1'b0, 1'b1, 12'h1C0, 8'h1C});
      vecs.push_back('{12'h400, 1'b0, 1'b1, 12'h280, 8'h28});
      drop_raw = 12'h5BA;
`else
      vecs.push_back('{12'hA5C, 1'b0, 1'b1, 12'hA5C, 8'hA5});
      vecs.push_back('{12'h123, 1'b1, 1'b0, 12'hA5C, 8'hA5});
      vecs.push_back('{12'h000, 1'b0, 1'b1, 12'h000, 8'h00});
      vecs.push_back('{12'hFFF, 1'b0, 1'b1, 12'hFFF, 8'hFF});
      vecs.push_back('{12'h00F, 1'b0, 1'b1, 12'h00F, 8'h00});
      vecs.push_back('{12'h3C7, 1'b1, 1'b0, 12'h00F, 8'h00});
      vecs.push_back('{12'h5A3, 1'b0, 1'b1, 12'h5A3, 8'h5A});
      drop_raw = 12'h2D4;
`endif

      reset  = 1'b1;
      enable = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
      check("rst_sclk", {31'd0, adc_sclk}, 32'd0);
      check("rst_angle_raw", {20'd0, angle_raw}, 32'd0);
      check("rst_angle_out", {24'd0, angle_out}, 32'd0);
      check("rst_data_valid", {31'd0, data_valid}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_state", {29'd0, dbg_state}, 32'd0);
      reset  = 1'b0;
      enable = 1'b1;

      foreach (vecs[i])
         do_frame(vecs[i].code, vecs[i].nb, vecs[i].ev, vecs[i].raw, vecs[i].out, 1'b0);

      // reset just after the 8th SCLK rise aborts the frame
      m_code = 12'h777;
      m_null = 1'b0;
      wait_cs(1'b0, ok);
      check("mid_reset_cs_fall", {31'd0, ok}, 32'd1);
      for (int i = 0; i < 200 && rises < 8; i++) begin
         @(negedge clk); #1;
      end
      check("mid_reset_at_rise8", rises, 8);
      reset = 1'b1;
      @(negedge clk); #1;
      check("mid_reset_cs_n", {31'd0, adc_cs_n}, 32'd1);
      check("mid_reset_sclk", {31'd0, adc_sclk}, 32'd0);
      check("mid_reset_angle_out", {24'd0, angle_out}, 32'd0);
      check("mid_reset_angle_raw", {20'd0, angle_raw}, 32'd0);
      check("mid_reset_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b0;
      do_frame(12'h6B2, 1'b0, 1'b1, 12'h6B2, 8'h6B, 1'b0);

      // enable low: no frame for three periods
      enable = 1'b0;
      snap = cs_falls;
      repeat (3 * SP) @(negedge clk);
      #1;
      check("disabled_no_frames", cs_falls - snap, 0);
      check("disabled_cs_idle", {31'd0, adc_cs_n}, 32'd1);

      // enable dropped right after cs_n falls: frame still completes
      enable = 1'b1;
      do_frame(12'h2D4, 1'b0, 1'b1, drop_raw, drop_raw[11:4], 1'b1);
      snap = cs_falls;
      repeat (SP + 10) @(negedge clk);
      #1;
      check("after_drop_no_frames", cs_falls - snap, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
